// File: rtl/uart_tx_arb_pkg.sv
// Shared encodings for the management-UART transmit arbiter and its serializer.
package uart_tx_arb_pkg;

    localparam int FRAME_DATA_BITS = 8;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCK
    } arb_state_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } ser_state_e;

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 transmit serializer with per-frame latched bit period.
// Define UART_TX_ARB_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_serializer
    import uart_tx_arb_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             core_clk,
    input  logic             core_rst,
    input  logic             load,
    input  logic [7:0]       data,
    input  logic [DIV_W-1:0] clk_div,
    output logic             ser_tx,
    output logic             idle,
    output logic             busy
);

    ser_state_e       state_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       sh_q;
    logic             ser_q;
`ifdef UART_TX_ARB_PARITY_EN
    logic             par_q;
`endif

    logic last_tick;
    assign last_tick = (cnt_q == div_q);

    // Ready for a new byte in the final stop cycle so frames abut with no idle bit.
    assign idle   = (state_q == S_IDLE) || ((state_q == S_STOP) && last_tick);
    assign busy   = (state_q != S_IDLE);
    assign ser_tx = ser_q;

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            state_q <= S_IDLE;
            ser_q   <= 1'b1;
            div_q   <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
`ifdef UART_TX_ARB_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else if (load && idle) begin
            state_q <= S_START;
            ser_q   <= 1'b0;
            div_q   <= clk_div;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= data;
`ifdef UART_TX_ARB_PARITY_EN
            par_q   <= ^data;
`endif
        end else if (state_q != S_IDLE) begin
            if (!last_tick) begin
                cnt_q <= cnt_q + 1'b1;
            end else begin
                cnt_q <= '0;
                case (state_q)
                    S_START: begin
                        state_q <= S_DATA;
                        ser_q   <= sh_q[0];
                        sh_q    <= {1'b0, sh_q[7:1]};
                    end
                    S_DATA: begin
                        if (bit_q == 3'(FRAME_DATA_BITS - 1)) begin
`ifdef UART_TX_ARB_PARITY_EN
                            state_q <= S_PARITY;
                            ser_q   <= par_q;
`else
                            state_q <= S_STOP;
                            ser_q   <= 1'b1;
`endif
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            ser_q <= sh_q[0];
                            sh_q  <= {1'b0, sh_q[7:1]};
                        end
                    end
                    S_PARITY: begin
                        state_q <= S_STOP;
                        ser_q   <= 1'b1;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        ser_q   <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter sharing one UART transmit line among NREQ requesters.
// Frame format follows UART_TX_ARB_PARITY_EN (8E1 when defined, 8N1 otherwise).
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int NREQ         = 3,
    parameter int LOCK_TIMEOUT = 1024,
    parameter int DIV_W        = 16
) (
    input  logic              core_clk,
    input  logic              core_rst,
    input  logic              enable,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic              ser_tx,
    output logic              busy,
    output logic              grant_valid,
    output logic [2:0]        grant_id
);

    localparam int TW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;

    arb_state_e    state_q;
    logic [2:0]    grant_id_q;
    logic [2:0]    ptr_q;
    logic [2:0]    ptr_d;
    logic [TW-1:0] timer_q;

    logic       ser_idle;
    logic       ser_busy;
    logic [7:0] sel_data;
    logic       sel_last;
    logic       owner_valid;
    logic [2:0] win;
    logic       accept;
    logic       tick;
    logic       timeout;
    logic       release_lock;

    always_comb begin
        sel_data    = '0;
        sel_last    = 1'b0;
        owner_valid = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id_q == 3'(i)) begin
                sel_data    = req_data[8*i +: 8];
                sel_last    = req_last[i];
                owner_valid = req_valid[i];
            end
        end
    end

    // First valid requester at or after the pointer, wrapping.
    always_comb begin
        int  idx;
        logic found;
        win   = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = 3'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if ((state_q == ARB_LOCK) && enable && ser_idle) begin
            for (int i = 0; i < NREQ; i++) begin
                req_ready[i] = (grant_id_q == 3'(i));
            end
        end
    end

    assign accept       = |(req_valid & req_ready);
    assign tick         = !owner_valid && !ser_busy;
    assign timeout      = (LOCK_TIMEOUT != 0) && tick && (timer_q == TW'(LOCK_TIMEOUT - 1));
    assign release_lock = (accept && sel_last) || timeout;
    assign ptr_d        = (grant_id_q == 3'(NREQ - 1)) ? 3'd0 : grant_id_q + 3'd1;

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            state_q    <= ARB_IDLE;
            grant_id_q <= '0;
            ptr_q      <= '0;
            timer_q    <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (enable && |req_valid) begin
                        state_q    <= ARB_LOCK;
                        grant_id_q <= win;
                        timer_q    <= '0;
                    end
                end
                default: begin
                    if (release_lock) begin
                        state_q <= ARB_IDLE;
                        ptr_q   <= ptr_d;
                        timer_q <= '0;
                    end else if (accept) begin
                        timer_q <= '0;
                    end else if (tick && (LOCK_TIMEOUT != 0)) begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
            endcase
        end
    end

    uart_tx_serializer #(.DIV_W(DIV_W)) u_ser (
        .core_clk (core_clk),
        .core_rst (core_rst),
        .load     (accept),
        .data     (sel_data),
        .clk_div  (clk_div),
        .ser_tx   (ser_tx),
        .idle     (ser_idle),
        .busy     (ser_busy)
    );

    assign busy        = ser_busy;
    assign grant_valid = (state_q == ARB_LOCK);
    assign grant_id    = grant_id_q;

endmodule
